// File: rtl/bus_data_responder.sv
// Data-port responder for the single-cycle core: byte-addressable RAM plus a small
// MMIO block (console TX FIFO, sticky status flags, free-running cycle counter).
module bus_data_responder #(
    parameter int RAM_WORDS  = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] bus_address,
    input  logic [31:0] bus_wr_data,
    input  logic        bus_wr_enable,
    input  logic [2:0]  bus_write_length,
    output logic [31:0] bus_read_data,
    output logic [7:0]  console_data,
    output logic        console_valid,
    input  logic        console_ready
);

    localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [31:0] RAM_BYTES    = 32'(RAM_WORDS * 4);
    localparam logic [31:0] CONSOLE_ADDR = 32'h8000_0000;
    localparam logic [31:0] STATUS_ADDR  = 32'h8000_0004;
    localparam logic [31:0] CYCLE_ADDR   = 32'h8000_0008;
    localparam logic [PW:0] FULL_CNT     = (PW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] LEN_BYTE = 3'b000;
    localparam logic [2:0] LEN_HALF = 3'b001;
    localparam logic [2:0] LEN_WORD = 3'b010;

    logic [31:0]   ram [RAM_WORDS];
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          overflow, bus_error;
    logic [31:0]   cycle_cnt;

    logic [AW-1:0] ram_idx;
    logic          is_ram, is_console, is_status, is_cycle;
    logic          illegal, wr_ok;
    logic [3:0]    be;
    logic [31:0]   lane_data;
    logic          empty, full, pop, push_req, push;
    logic          ovf_set, ovf_clr, err_set, err_clr;
    logic [31:0]   status_word;

    assign ram_idx    = bus_address[AW+1:2];
    assign is_ram     = bus_address < RAM_BYTES;
    assign is_console = bus_address == CONSOLE_ADDR;
    assign is_status  = bus_address == STATUS_ADDR;
    assign is_cycle   = bus_address == CYCLE_ADDR;

    // Legality is independent of the target address, so unmapped stores still flag errors.
    assign illegal = (bus_write_length > LEN_WORD) ||
                     (bus_write_length == LEN_HALF && bus_address[0]) ||
                     (bus_write_length == LEN_WORD && bus_address[1:0] != 2'b00);
    assign wr_ok   = bus_wr_enable && !illegal;

    always_comb begin
        be        = 4'b0000;
        lane_data = bus_wr_data;
        case (bus_write_length)
            LEN_BYTE: begin
                be        = 4'b0001 << bus_address[1:0];
                lane_data = {4{bus_wr_data[7:0]}};
            end
            LEN_HALF: begin
                be        = bus_address[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{bus_wr_data[15:0]}};
            end
            LEN_WORD: be = 4'b1111;
            default:  be = 4'b0000;
        endcase
    end

    // RAM contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (wr_ok && is_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) ram[ram_idx][8*i +: 8] <= lane_data[8*i +: 8];
            end
        end
    end

    // Console handshake: a byte transfers on any rising edge where console_valid and
    // console_ready are both high; console_data holds the head until that happens.
    assign empty         = count == '0;
    assign full          = count == FULL_CNT;
    assign pop           = !empty && console_ready;
    assign push_req      = wr_ok && is_console;
    assign push          = push_req && (!full || pop);
    assign console_valid = !empty;
    assign console_data  = fifo_mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= 8'h00;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= bus_wr_data[7:0];
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + (PW + 1)'(1);
            else if (pop && !push) count <= count - (PW + 1)'(1);
        end
    end

    assign ovf_set = push_req && full && !pop;
    assign err_set = bus_wr_enable && illegal;
    assign ovf_clr = wr_ok && is_status && bus_wr_data[2];
    assign err_clr = wr_ok && is_status && bus_wr_data[3];

    // A set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            bus_error <= 1'b0;
            cycle_cnt <= 32'd0;
        end else begin
            overflow  <= ovf_set || (overflow && !ovf_clr);
            bus_error <= err_set || (bus_error && !err_clr);
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    assign status_word = {24'd0, 4'(count), bus_error, overflow, full, empty};

    always_comb begin
        bus_read_data = 32'd0;
        if (is_ram)         bus_read_data = ram[ram_idx] >> {bus_address[1:0], 3'b000};
        else if (is_status) bus_read_data = status_word;
        else if (is_cycle)  bus_read_data = cycle_cnt;
    end

endmodule

// File: tb/tb_bus_data_responder.sv
// Self-checking bench for bus_data_responder: directed scenarios plus randomized
// traffic checked against a byte-array / queue reference model.
module tb_bus_data_responder;

    localparam int          DEPTH        = 4;
    localparam logic [31:0] CONSOLE_ADDR = 32'h8000_0000;
    localparam logic [31:0] STATUS_ADDR  = 32'h8000_0004;
    localparam logic [31:0] CYCLE_ADDR   = 32'h8000_0008;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] bus_address = 32'd0;
    logic [31:0] bus_wr_data = 32'd0;
    logic        bus_wr_enable = 1'b0;
    logic [2:0]  bus_write_length = 3'd0;
    logic [31:0] bus_read_data;
    logic [7:0]  console_data;
    logic        console_valid;
    logic        console_ready = 1'b0;

    bus_data_responder #(.RAM_WORDS(256), .FIFO_DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus_address      (bus_address),
        .bus_wr_data      (bus_wr_data),
        .bus_wr_enable    (bus_wr_enable),
        .bus_write_length (bus_write_length),
        .bus_read_data    (bus_read_data),
        .console_data     (console_data),
        .console_valid    (console_valid),
        .console_ready    (console_ready)
    );

    always #10 clk = ~clk;

    // Reference model
    logic [7:0]  ref_mem [1024];
    logic [7:0]  ref_q [$];
    logic        ref_ovf = 1'b0;
    logic        ref_err = 1'b0;
    logic [31:0] ref_cycle = 32'd0;
    int          n_checks = 0;
    int          n_pass = 0;

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        logic [31:0] w;
        logic [9:0]  b;
        exp_read = 32'd0;
        if (a < 32'd1024) begin
            b = {a[9:2], 2'b00};
            w = {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
            exp_read = w >> (8 * a[1:0]);
        end else if (a == STATUS_ADDR) begin
            exp_read = {24'd0, 4'(ref_q.size()), ref_err, ref_ovf,
                        ref_q.size() == DEPTH, ref_q.size() == 0};
        end else if (a == CYCLE_ADDR) begin
            exp_read = ref_cycle;
        end
    endfunction

    task automatic model_reset();
        ref_q.delete();
        ref_ovf   = 1'b0;
        ref_err   = 1'b0;
        ref_cycle = 32'd0;
    endtask

    // Advance one clock, updating the model from the inputs presented before the edge.
    task automatic step();
        logic [31:0] a, d;
        logic [2:0]  len;
        logic        legal, pop, do_push, set_ovf, set_err, clr_ovf, clr_err;
        if (!rst_n) begin
            model_reset();
            @(posedge clk);
            #1;
            return;
        end
        a = bus_address; d = bus_wr_data; len = bus_write_length;
        legal   = !((len > 3'd2) || (len == 3'd1 && a[0]) || (len == 3'd2 && a[1:0] != 2'b00));
        pop     = ref_q.size() > 0 && console_ready;
        do_push = 1'b0; set_ovf = 1'b0; clr_ovf = 1'b0; clr_err = 1'b0;
        set_err = bus_wr_enable && !legal;
        if (bus_wr_enable && legal) begin
            if (a < 32'd1024) begin
                if (len == 3'd0) ref_mem[a[9:0]] = d[7:0];
                else if (len == 3'd1) begin
                    ref_mem[a[9:0]]     = d[7:0];
                    ref_mem[a[9:0] + 1] = d[15:8];
                end else begin
                    for (int i = 0; i < 4; i++) ref_mem[a[9:0] + i] = d[8*i +: 8];
                end
            end else if (a == CONSOLE_ADDR) begin
                if (ref_q.size() == DEPTH && !pop) set_ovf = 1'b1;
                else do_push = 1'b1;
            end else if (a == STATUS_ADDR) begin
                clr_ovf = d[2];
                clr_err = d[3];
            end
        end
        @(posedge clk);
        if (pop) void'(ref_q.pop_front());
        if (do_push) ref_q.push_back(d[7:0]);
        ref_ovf   = set_ovf || (ref_ovf && !clr_ovf);
        ref_err   = set_err || (ref_err && !clr_err);
        ref_cycle = ref_cycle + 32'd1;
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] len);
        bus_address      = a;
        bus_wr_data      = d;
        bus_write_length = len;
        bus_wr_enable    = 1'b1;
        step();
        bus_wr_enable    = 1'b0;
    endtask

    task automatic set_read(input logic [31:0] a);
        bus_wr_enable = 1'b0;
        bus_address   = a;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_checks++;
        if (console_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", console_valid);
        else n_pass++;
        n_checks++;
        if (console_data !== 8'h00) $display("FAIL reset_data: got %h expected 00", console_data);
        else n_pass++;
        set_read(STATUS_ADDR);
        n_checks++;
        if (bus_read_data !== 32'h1) $display("FAIL reset_status: got %h expected 00000001", bus_read_data);
        else n_pass++;
        set_read(CYCLE_ADDR);
        n_checks++;
        if (bus_read_data !== 32'h0) $display("FAIL reset_cycle: got %h expected 00000000", bus_read_data);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic preload_ram();
        logic [31:0] a;
        for (int w = 0; w < 64; w++) do_write(32'(w * 4), $urandom, 3'd2);
        for (int k = 0; k < 8; k++) begin
            a = 32'($urandom_range(0, 255));
            set_read(a);
            n_checks++;
            if (bus_read_data !== exp_read(a))
                $display("FAIL preload_read @%h: got %h expected %h", a, bus_read_data, exp_read(a));
            else n_pass++;
        end
    endtask

    task automatic test_store_lanes();
        logic [31:0] a;
        logic [2:0]  len;
        do_write(32'h10, 32'h1122_3344, 3'd2);
        do_write(32'h11, 32'h0000_00AA, 3'd0);
        bus_address = 32'h12; bus_wr_data = 32'h0000_BBCC;
        bus_write_length = 3'd1; bus_wr_enable = 1'b1;
        #1;
        n_checks++;
        if (bus_read_data !== 32'h0000_1122)
            $display("FAIL read_during_write: got %h expected 00001122", bus_read_data);
        else n_pass++;
        step();
        bus_wr_enable = 1'b0;
        set_read(32'h10);
        n_checks++;
        if (bus_read_data !== 32'hBBCC_AA44) $display("FAIL lanes_lw10: got %h expected bbccaa44", bus_read_data);
        else n_pass++;
        set_read(32'h13);
        n_checks++;
        if (bus_read_data !== 32'h0000_00BB) $display("FAIL lanes_rd13: got %h expected 000000bb", bus_read_data);
        else n_pass++;
        for (int k = 0; k < 40; k++) begin
            len = 3'($urandom_range(0, 2));
            a   = 32'($urandom_range(0, 255));
            if (len == 3'd1) a[0] = 1'b0;
            if (len == 3'd2) a[1:0] = 2'b00;
            do_write(a, $urandom, len);
            a = 32'($urandom_range(0, 255));
            set_read(a);
            n_checks++;
            if (bus_read_data !== exp_read(a))
                $display("FAIL rand_store_read @%h: got %h expected %h", a, bus_read_data, exp_read(a));
            else n_pass++;
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] w20, w24;
        set_read(32'h20); w20 = bus_read_data;
        set_read(32'h24); w24 = bus_read_data;
        do_write(32'h21, 32'hDEAD_BEEF, 3'd1);
        do_write(32'h22, 32'hDEAD_BEEF, 3'd2);
        do_write(32'h20, 32'hDEAD_BEEF, 3'd5);
        set_read(32'h20);
        n_checks++;
        if (bus_read_data !== exp_read(32'h20) || bus_read_data !== w20)
            $display("FAIL misaligned_w20: got %h expected %h", bus_read_data, exp_read(32'h20));
        else n_pass++;
        set_read(32'h24);
        n_checks++;
        if (bus_read_data !== exp_read(32'h24) || bus_read_data !== w24)
            $display("FAIL misaligned_w24: got %h expected %h", bus_read_data, exp_read(32'h24));
        else n_pass++;
        set_read(STATUS_ADDR);
        n_checks++;
        if (bus_read_data !== 32'h9) $display("FAIL status_buserr_set: got %h expected 00000009", bus_read_data);
        else n_pass++;
        do_write(STATUS_ADDR, 32'h8, 3'd2);
        set_read(STATUS_ADDR);
        n_checks++;
        if (bus_read_data !== 32'h1) $display("FAIL status_buserr_clr: got %h expected 00000001", bus_read_data);
        else n_pass++;
    endtask

    task automatic test_fifo_fill_drain();
        console_ready = 1'b0;
        for (int b = 8'h41; b <= 8'h44; b++) do_write(CONSOLE_ADDR, 32'(b), 3'd0);
        set_read(STATUS_ADDR);
        n_checks++;
        if (bus_read_data !== 32'h42) $display("FAIL fifo_full_status: got %h expected 00000042", bus_read_data);
        else n_pass++;
        do_write(CONSOLE_ADDR, 32'h45, 3'd0);
        set_read(STATUS_ADDR);
        n_checks++;
        if (bus_read_data !== 32'h46) $display("FAIL fifo_overflow_status: got %h expected 00000046", bus_read_data);
        else n_pass++;
        console_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (console_valid !== 1'b1 || console_data !== 8'(8'h41 + k))
                $display("FAIL drain_byte%0d: got valid=%b data=%h expected valid=1 data=%h",
                         k, console_valid, console_data, 8'(8'h41 + k));
            else n_pass++;
            step();
        end
        n_checks++;
        if (console_valid !== 1'b0) $display("FAIL drain_empty: got valid=%b expected 0", console_valid);
        else n_pass++;
        console_ready = 1'b0;
        do_write(STATUS_ADDR, 32'h4, 3'd2);
        set_read(STATUS_ADDR);
        n_checks++;
        if (bus_read_data !== 32'h1) $display("FAIL overflow_clear: got %h expected 00000001", bus_read_data);
        else n_pass++;
    endtask

    task automatic test_full_push_pop();
        console_ready = 1'b0;
        for (int k = 0; k < 4; k++)
            do_write(CONSOLE_ADDR, $urandom, (k == 2) ? 3'd2 : 3'd0);
        console_ready = 1'b1;
        do_write(CONSOLE_ADDR, 32'h55, 3'd0);
        set_read(STATUS_ADDR);
        n_checks++;
        if (bus_read_data !== 32'h42) $display("FAIL push_pop_status: got %h expected 00000042", bus_read_data);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (console_valid !== 1'b1 || console_data !== ref_q[0] || (k == 3 && console_data !== 8'h55))
                $display("FAIL push_pop_byte%0d: got valid=%b data=%h expected valid=1 data=%h",
                         k, console_valid, console_data, ref_q[0]);
            else n_pass++;
            step();
        end
        n_checks++;
        if (console_valid !== 1'b0) $display("FAIL push_pop_empty: got valid=%b expected 0", console_valid);
        else n_pass++;
        console_ready = 1'b0;
    endtask

    task automatic test_cycle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) step();
        set_read(CYCLE_ADDR);
        n_checks++;
        if (bus_read_data !== 32'd10) $display("FAIL cycle_10: got %0d expected 10", bus_read_data);
        else n_pass++;
        do_write(CYCLE_ADDR, 32'h1234, 3'd2);
        set_read(CYCLE_ADDR);
        n_checks++;
        if (bus_read_data !== 32'd11 || bus_read_data !== ref_cycle)
            $display("FAIL cycle_write_ignored: got %0d expected %0d", bus_read_data, ref_cycle);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        console_ready = 1'b0;
        do_write(32'h30, 32'hCAFE_F00D, 3'd2);
        do_write(CONSOLE_ADDR, 32'h61, 3'd0);
        do_write(CONSOLE_ADDR, 32'h62, 3'd0);
        do_write(32'h40, 32'h0, 3'd7);
        n_checks++;
        if (console_valid !== 1'b1 || console_data !== 8'h61)
            $display("FAIL pre_reset_fifo: got valid=%b data=%h expected valid=1 data=61", console_valid, console_data);
        else n_pass++;
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (console_valid !== 1'b0) $display("FAIL async_reset_valid: got %b expected 0", console_valid);
        else n_pass++;
        set_read(STATUS_ADDR);
        n_checks++;
        if (bus_read_data !== 32'h1) $display("FAIL async_reset_status: got %h expected 00000001", bus_read_data);
        else n_pass++;
        set_read(32'h30);
        n_checks++;
        if (bus_read_data !== 32'hCAFE_F00D) $display("FAIL ram_retained: got %h expected cafef00d", bus_read_data);
        else n_pass++;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_random_traffic();
        logic [31:0] a;
        for (int k = 0; k < 300; k++) begin
            console_ready = ($urandom_range(0, 2) == 0);
            bus_wr_enable = 1'b1;
            bus_wr_data   = $urandom;
            case ($urandom_range(0, 9))
                0, 1, 2: begin
                    bus_address      = 32'($urandom_range(0, 255));
                    bus_write_length = 3'($urandom_range(0, 4));
                end
                3, 4, 5: begin
                    bus_address      = CONSOLE_ADDR;
                    bus_write_length = 3'($urandom_range(0, 2));
                end
                6: begin
                    bus_address      = STATUS_ADDR;
                    bus_write_length = 3'($urandom_range(0, 3));
                end
                7: begin
                    bus_address      = ($urandom_range(0, 1) == 0) ? CYCLE_ADDR : 32'h4000_0000;
                    bus_write_length = 3'($urandom_range(0, 2));
                end
                default: bus_wr_enable = 1'b0;
            endcase
            #1;
            n_checks++;
            if (console_valid !== (ref_q.size() != 0) ||
                (ref_q.size() != 0 && console_data !== ref_q[0]))
                $display("FAIL rand_console cyc%0d: got valid=%b data=%h expected valid=%b data=%h",
                         k, console_valid, console_data, ref_q.size() != 0,
                         (ref_q.size() != 0) ? ref_q[0] : 8'h00);
            else n_pass++;
            step();
            case ($urandom_range(0, 5))
                0, 1:    a = 32'($urandom_range(0, 255));
                2:       a = STATUS_ADDR;
                3:       a = CYCLE_ADDR;
                4:       a = CONSOLE_ADDR;
                default: a = ($urandom_range(0, 1) == 0) ? 32'h0000_0400 : 32'h8000_000C;
            endcase
            set_read(a);
            n_checks++;
            if (bus_read_data !== exp_read(a))
                $display("FAIL rand_read cyc%0d @%h: got %h expected %h", k, a, bus_read_data, exp_read(a));
            else n_pass++;
        end
        console_ready = 1'b0;
        bus_wr_enable = 1'b0;
    endtask

    initial begin
        test_reset();
        preload_ram();
        test_store_lanes();
        test_misaligned();
        test_fifo_fill_drain();
        test_full_push_pop();
        test_cycle();
        test_async_reset();
        test_random_traffic();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_data_responder.md
# bus_data_responder

Bus responder for the single-cycle core's data port: services load/store accesses to a byte-addressable data RAM and a small memory-mapped I/O region (console TX FIFO, status register, free-running cycle counter). Sits on the core's `bus_*` signals and answers reads combinationally in the same cycle. Commits writes on the rising clock edge. Drains the console FIFO to an external sink through a valid/ready handshake.

## Interface
- `RAM_WORDS`, 256: data RAM depth in 32-bit words; RAM spans byte addresses 0 to RAM_WORDS*4-1.
- `FIFO_DEPTH`, 4: console FIFO entries; power of two, 2..8.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `bus_address` in 32: byte address from the core.
- `bus_wr_data` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `bus_wr_enable` in 1: store strobe, sampled at the rising edge.
- `bus_write_length` in 3: store size; 000 byte, 001 half, 010 word, others illegal.
- `bus_read_data` out 32: load data, combinational.
- `console_data` out 8: FIFO head byte.
- `console_valid` out 1: FIFO not empty.
- `console_ready` in 1: sink accepts head byte.

## Operation
- Address map:
  - RAM: `bus_address` < RAM_WORDS*4.
  - CONSOLE_TX: 0x8000_0000.
  - STATUS: 0x8000_0004.
  - CYCLE: 0x8000_0008.
  - Any other address reads 0; writes to it are dropped with no error.
- Read data:
  - RAM: the addressed aligned word shifted right by 8*`bus_address`[1:0], zero-filled. The core sign/zero-extends.
  - CONSOLE_TX reads 0.
  - STATUS layout, with unused bits 0:
    - [0] empty.
    - [1] full.
    - [2] overflow, sticky.
    - [3] bus_error, sticky.
    - [7:4] count.
  - CYCLE reads the counter value.
- Store legality, applied at every address. A store is illegal if any of the following holds:
  - length is 011..111;
  - half with `bus_address`[0]=1;
  - word with `bus_address`[1:0]≠00.
- An illegal store is dropped and sets bus_error.
- RAM store:
  - byte writes lane `bus_address`[1:0];
  - half writes lanes {`bus_address`[1],0} and +1;
  - word writes all lanes;
  - other lanes are unchanged.
- CONSOLE_TX store of any legal length pushes `bus_wr_data`[7:0].
- FIFO push/pop rules:
  - If full and not popping in the same cycle, the push is dropped and overflow is set.
  - Push into a full FIFO with a simultaneous pop is accepted.
  - Pop occurs when `console_valid` && `console_ready`.
  - Pop on empty is a no-op.
- STATUS store (legal only): `bus_wr_data`[2]=1 clears overflow and `bus_wr_data`[3]=1 clears bus_error. A set event in the same cycle wins over a clear.
- CYCLE increments every clock, wraps from 0xFFFF_FFFF to 0, and ignores writes.

## Timing
- Reset (async assert, state cleared immediately):
  - FIFO empty, pointers 0, storage 0.
  - `console_valid`=0, `console_data`=0x00.
  - overflow=0, bus_error=0, CYCLE=0.
  - RAM contents are not cleared.
  - STATUS reads 0x0000_0001.
- Reads: zero latency, combinational from `bus_address` and current state. A read in the same cycle as a write returns the pre-edge value; the new value is visible the cycle after the edge.
- Push at edge N: `console_valid`=1 and `console_data` show the byte after edge N. Count updates at the same edge.
- Pop at edge N: the next entry appears after edge N; `console_valid` drops after edge N if that was the last entry.
- `console_data` is stable while `console_valid`=1 and `console_ready`=0.
- Reset asserted mid-transfer discards all FIFO contents and sticky flags; RAM is retained.

## Test plan
- Word/half/byte store lanes: SW 0x11223344 @0x10; SB 0xAA @0x11; SH 0xBBCC @0x12. LW 0x10 -> 0xBBCCAA44; read @0x13 -> 0x000000BB.
- Misaligned store: SH @0x21 and SW @0x22 -> RAM unchanged, STATUS bit3=1. Then STATUS write 0x8 -> STATUS bit3=0.
- Console FIFO with FIFO_DEPTH=4 and `console_ready`=0:
  - Push 0x41..0x44: STATUS=0x42 (count 4, full).
  - Fifth push 0x45: dropped; STATUS=0x46.
  - Raise `console_ready`: bytes 0x41,0x42,0x43,0x44 appear on consecutive cycles, then `console_valid`=0.
- Full FIFO with simultaneous push 0x55 and pop: push accepted, count stays 4, overflow stays 0, and 0x55 is the last byte out.
- CYCLE: read after 10 clocks following reset release -> 10. A write of 0x1234 to CYCLE has no effect.
- Async reset asserted between edges with 2 FIFO entries: `console_valid`=0 immediately, STATUS=0x1, and a RAM word written earlier still reads back.
